cd_reload_counter: RTL and testbench

Loadable, cascadable down counter: the count-down counterpart of the team's 4-bit up counter with CE/TC/CEO chaining. It is built from identical 4-bit down-counting slices joined by the CE→CEO ripple chain. It supports a parallel load and optional auto-reload of the last loaded period, so it can serve as a programmable interval timer or a divide-by-N prescaler feeding downstream up counters.

---
 rtl/cd_reload_counter_pkg.sv | 16 +
 rtl/cd_reload_counter_slice.sv | 45 ++++
 rtl/cd_reload_counter.sv | 80 ++++++++
 tb/tb_cd_reload_counter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cd_reload_counter_pkg.sv
// -----------------------------------------------------------------------------
// cd_reload_counter_pkg
// Shared constants and helpers for the nibble-sliced counter family (the up
// counters and cd_reload_counter).
//   NIBBLE_W      : width of one counter slice (4 bits)
//   counter_width : full counter width for a given number of slices
// -----------------------------------------------------------------------------
package cd_reload_counter_pkg;

    localparam int NIBBLE_W = 4;

    function automatic int counter_width(input int nibbles);
        return NIBBLE_W * nibbles;
    endfunction

endpackage

// File: rtl/cd_reload_counter_slice.sv
// -----------------------------------------------------------------------------
// cd4_slice
// One 4-bit down-counting slice with synchronous load and CE/TC/CEO chaining.
// Ports:
//   CLK  in  clock, rising edge
//   R    in  asynchronous active-high reset (count -> 0)
//   CE   in  count enable; decrement (0 wraps to F) when high and L low
//   L    in  synchronous load of D; wins over CE
//   D    in  [3:0] load value
//   Q    out [3:0] registered count
//   TC   out terminal count, Q == 0
//   CEO  out cascade enable, TC & CE
// -----------------------------------------------------------------------------
module cd4_slice
    import cd_reload_counter_pkg::*;
(
    input  logic                CLK,
    input  logic                R,
    input  logic                CE,
    input  logic                L,
    input  logic [NIBBLE_W-1:0] D,
    output logic [NIBBLE_W-1:0] Q,
    output logic                TC,
    output logic                CEO
);

    logic [NIBBLE_W-1:0] r_q;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            r_q <= '0;
        end else if (L) begin
            r_q <= D;
        end else if (CE) begin
            // Unsigned subtraction wraps 0 -> F, which is the borrow into
            // this slice from the chain below.
            r_q <= r_q - NIBBLE_W'(1);
        end
    end

    assign Q   = r_q;
    assign TC  = (r_q == '0);
    assign CEO = TC & CE;

endmodule

// File: rtl/cd_reload_counter.sv
// -----------------------------------------------------------------------------
// cd_reload_counter
// Loadable, cascadable down counter with optional auto-reload of the last
// loaded period. Built from NIBBLES cd4_slice instances joined by the
// CE -> CEO ripple chain.
// Parameters:
//   NIBBLES  number of 4-bit slices (>= 1); width W = 4*NIBBLES
// Ports:
//   CLK  in  clock, rising edge
//   R    in  asynchronous active-high reset (Q = 0, P = 0)
//   CE   in  count enable
//   L    in  synchronous load of D into count and period register
//   D    in  [W-1:0] load value
//   RLD  in  auto-reload enable, only its value at the zero/CE edge matters
//   Q    out [W-1:0] registered count
//   TC   out terminal count, Q == 0
//   CEO  out cascade enable, TC & CE (CEO of the last slice)
// -----------------------------------------------------------------------------
module cd_reload_counter
    import cd_reload_counter_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                              CLK,
    input  logic                              R,
    input  logic                              CE,
    input  logic                              L,
    input  logic [counter_width(NIBBLES)-1:0] D,
    input  logic                              RLD,
    output logic [counter_width(NIBBLES)-1:0] Q,
    output logic                              TC,
    output logic                              CEO
);

    localparam int W = counter_width(NIBBLES);

    // Period register: written only by L (and cleared by R); reload reads it
    // but never modifies it.
    logic [W-1:0]       r_period;
    logic [NIBBLES:0]   w_ce_chain;
    logic [NIBBLES-1:0] w_tc;
    logic               w_tc_all;
    logic               w_load;
    logic [W-1:0]       w_load_val;

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            r_period <= '0;
        end else if (L) begin
            r_period <= D;
        end
    end

    assign w_tc_all = &w_tc;

    // One global load strobe covers both explicit load and auto-reload, so
    // every slice takes its nibble of the selected value on the same edge.
    // L has priority, so the data mux selects D whenever L is high.
    assign w_load     = L | (CE & RLD & w_tc_all);
    assign w_load_val = L ? D : r_period;

    assign w_ce_chain[0] = CE;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_slice
        cd4_slice u_slice (
            .CLK (CLK),
            .R   (R),
            .CE  (w_ce_chain[k]),
            .L   (w_load),
            .D   (w_load_val[k*NIBBLE_W +: NIBBLE_W]),
            .Q   (Q[k*NIBBLE_W +: NIBBLE_W]),
            .TC  (w_tc[k]),
            .CEO (w_ce_chain[k+1])
        );
    end

    assign TC  = w_tc_all;
    assign CEO = w_ce_chain[NIBBLES];

endmodule

// File: tb/tb_cd_reload_counter.sv
// Directed, table-driven bench for cd_reload_counter (NIBBLES = 4).
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. after the rising edge that consumed the inputs, while the same
// CE is still applied (so CEO is expected as TC & that vector's CE).
module tb_cd_reload_counter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         r   = 1'b0;
  logic         ce  = 1'b0;
  logic         l   = 1'b0;
  logic         rld = 1'b0;
  logic [W-1:0] d   = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         ceo;

  int n_compared   = 0;
  int n_mismatched = 0;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  cd_reload_counter #(.NIBBLES(4)) dut (
    .CLK (clk),
    .R   (r),
    .CE  (ce),
    .L   (l),
    .D   (d),
    .RLD (rld),
    .Q   (q),
    .TC  (tc),
    .CEO (ceo)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic         r;
    logic         l;
    logic         ce;
    logic         rld;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_tc;
    logic         exp_ceo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r_i, input logic l_i, input logic ce_i,
                              input logic rld_i, input logic [W-1:0] d_i,
                              input logic [W-1:0] q_e, input logic tc_e,
                              input logic ceo_e);
    vec_t v;
    v.r = r_i; v.l = l_i; v.ce = ce_i; v.rld = rld_i; v.d = d_i;
    v.exp_q = q_e; v.exp_tc = tc_e; v.exp_ceo = ceo_e;
    return v;
  endfunction

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] e_q,
                               input logic e_tc, input logic e_ceo);
    check({tag, ".Q"},   q,          e_q);
    check({tag, ".TC"},  {15'd0, tc},  {15'd0, e_tc});
    check({tag, ".CEO"}, {15'd0, ceo}, {15'd0, e_ceo});
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    //                r  l  ce rld d        q        tc ceo
    vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0)); // reset
    // load 3 and count down
    vecs.push_back(mk(0, 1, 0, 0, 16'h0003, 16'h0003, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1));
    // wrap with RLD low
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'hFFFF, 0, 0));
    // borrow across slice boundary
    vecs.push_back(mk(0, 1, 0, 0, 16'h1000, 16'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0FFF, 0, 0));
    // auto-reload, period 2: L with CE high loads (no decrement)
    vecs.push_back(mk(0, 1, 1, 1, 16'h0002, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0002, 0, 0));
    // priority: load beats count, then hold with CE low
    vecs.push_back(mk(0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0010, 16'h0010, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0010, 0, 0));
    // degenerate period 0 with RLD high, CE toggling
    vecs.push_back(mk(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 0));
    // RLD only matters at the zero edge
    vecs.push_back(mk(0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'hFFFF, 0, 0));

    @(negedge clk);
    foreach (vecs[i]) begin
      r   = vecs[i].r;
      l   = vecs[i].l;
      ce  = vecs[i].ce;
      rld = vecs[i].rld;
      d   = vecs[i].d;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc,
                    vecs[i].exp_ceo);
    end

    // Asynchronous reset mid-cycle, with Q = 0x1234 and P = 0x1234.
    r = 0; l = 1; ce = 0; rld = 0; d = 16'h1234;
    @(negedge clk);
    check_outputs("preload", 16'h1234, 0, 0);
    l = 0; ce = 1; rld = 0; d = 16'h0000;
    #2 r = 1;                          // well before the next rising edge
    #1 check_outputs("async_rst", 16'h0000, 1, 1);

    // After release, CE with RLD high must reload P, which reset cleared.
    @(negedge clk);
    r = 0; ce = 1; rld = 1;
    @(negedge clk);
    check_outputs("post_rst_reload", 16'h0000, 1, 1);
    rld = 0;
    @(negedge clk);
    check_outputs("post_rst_wrap", 16'hFFFF, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
